serial_compare_ctrl: RTL and testbench

//  Sequences one shared 2-bit comparator slice over WIDTH-bit operands, MSB pair first.

---
 rtl/serial_compare_pkg.sv | 34 +++
 rtl/serial_compare_if.sv | 23 ++
 rtl/serial_compare_cmp2_slice.sv | 20 ++
 rtl/serial_compare_ctrl.sv | 158 +++++++++++++++
 tb/tb_serial_compare_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/serial_compare_pkg.sv
// Shared types and constants for the serial comparator controller.
// State encoding, slice width and the index-width helper live here.
package serial_compare_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int SLICE_W = 32'sd2;

    function automatic int clog2(input int value);
        int result;
        result = 32'sd0;
        for (int v = value - 32'sd1; v > 32'sd0; v = v >>> 32'sd1) begin
            result = result + 32'sd1;
        end
        return result;
    endfunction

    // The pair index needs at least one bit even when only one pass exists.
    function automatic int idx_width(input int width);
        int w;
        w = clog2(width / SLICE_W);
        if (w < 32'sd1) begin
            w = 32'sd1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/serial_compare_if.sv
// Operand/result bundle between an operand source and the serial comparator.
interface serial_compare_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             eq;
    logic             gt;
    logic             lt;

    modport master (
        output start, a, b,
        input  busy, done, eq, gt, lt
    );

    modport slave (
        input  start, a, b,
        output busy, done, eq, gt, lt
    );
endinterface

// File: rtl/serial_compare_cmp2_slice.sv
// Combinational 2-bit magnitude slice with EQ/GT cascade inputs from the
// more significant pairs already processed.
module cmp2_slice
    import serial_compare_pkg::*;
(
    input  logic               eq_in,
    input  logic               gt_in,
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    output logic               eq,
    output logic               gt
);

    // A lower pair only decides the result while everything above was equal.
    always_comb begin
        eq = eq_in & (a == b);
        gt = gt_in | (eq_in & (a > b));
    end

endmodule

// File: rtl/serial_compare_ctrl.sv
// Serial WIDTH-bit unsigned comparator: one 2-bit slice walked MSB pair first.
// Build option: define EARLY_EXIT_EN to finish on the first differing pair.
module serial_compare_ctrl
    import serial_compare_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_compare_if.slave  bus
);

    localparam int              PASSES   = WIDTH / SLICE_W;
    localparam int              IDX_W    = idx_width(WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PASSES - 32'sd1);

    state_t             state_r;
    state_t             state_s;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [IDX_W-1:0]   idx_r;
    logic               casc_eq_r;
    logic               casc_gt_r;
    logic               done_r;
    logic               res_eq_r;
    logic               res_gt_r;
    logic               res_lt_r;

    logic [SLICE_W-1:0] slice_a_s;
    logic [SLICE_W-1:0] slice_b_s;
    logic               slice_eq_s;
    logic               slice_gt_s;
    logic               last_pass_s;
    logic               exit_s;
    logic               accept_s;
    logic               finish_s;

    assign slice_a_s   = a_r[SLICE_W*int'(idx_r) +: SLICE_W];
    assign slice_b_s   = b_r[SLICE_W*int'(idx_r) +: SLICE_W];
    assign last_pass_s = (idx_r == {IDX_W{1'b0}});

`ifdef EARLY_EXIT_EN
    // Once the cascade drops EQ the answer cannot change, so stop there.
    assign exit_s = last_pass_s | (casc_eq_r & ~slice_eq_s);
`else
    assign exit_s = last_pass_s;
`endif

    cmp2_slice u_slice (
        .eq_in (casc_eq_r),
        .gt_in (casc_gt_r),
        .a     (slice_a_s),
        .b     (slice_b_s),
        .eq    (slice_eq_s),
        .gt    (slice_gt_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; a start in the DONE cycle chains straight into RUN.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        finish_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    accept_s = 1'b1;
                    state_s  = ST_RUN;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (exit_s) begin
                    finish_s = 1'b1;
                    state_s  = ST_DONE;
                end else begin
                    state_s  = ST_RUN;
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    accept_s = 1'b1;
                    state_s  = ST_RUN;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Operand capture, pair index and cascade registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r       <= {WIDTH{1'b0}};
            b_r       <= {WIDTH{1'b0}};
            idx_r     <= {IDX_W{1'b0}};
            casc_eq_r <= 1'b1;
            casc_gt_r <= 1'b0;
        end else if (accept_s) begin
            a_r       <= bus.a;
            b_r       <= bus.b;
            idx_r     <= IDX_LAST;
            casc_eq_r <= 1'b1;
            casc_gt_r <= 1'b0;
        end else if (state_r == ST_RUN) begin
            casc_eq_r <= slice_eq_s;
            casc_gt_r <= slice_gt_s;
            if (!last_pass_s) begin
                idx_r <= idx_r - IDX_W'(1);
            end else begin
                idx_r <= idx_r;
            end
        end else begin
            casc_eq_r <= casc_eq_r;
            casc_gt_r <= casc_gt_r;
        end
    end

    // Results become visible only on the finishing edge and are held after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_r   <= 1'b0;
            res_eq_r <= 1'b1;
            res_gt_r <= 1'b0;
            res_lt_r <= 1'b0;
        end else begin
            done_r <= finish_s;
            if (finish_s) begin
                res_eq_r <= slice_eq_s;
                res_gt_r <= slice_gt_s;
                res_lt_r <= ~slice_eq_s & ~slice_gt_s;
            end else begin
                res_eq_r <= res_eq_r;
                res_gt_r <= res_gt_r;
                res_lt_r <= res_lt_r;
            end
        end
    end

    assign bus.busy = (state_r == ST_RUN);
    assign bus.done = done_r;
    assign bus.eq   = res_eq_r;
    assign bus.gt   = res_gt_r;
    assign bus.lt   = res_lt_r;

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Bench for serial_compare_ctrl: 8-bit instance for vectors/random/corner
// sequences, 4-bit instance for an exhaustive sweep.
module tb_serial_compare_ctrl;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    serial_compare_if #(.WIDTH(8)) if8 ();
    serial_compare_if #(.WIDTH(4)) if4 ();

    serial_compare_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
    serial_compare_ctrl #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       eq;
        logic       gt;
        logic       lt;
        int         lat_base;
        int         lat_early;
        string      nm;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int w, input logic st, input logic [7:0] av, input logic [7:0] bv);
        if (w == 8) begin
            if8.start = st; if8.a = av; if8.b = bv;
        end else begin
            if4.start = st; if4.a = av[3:0]; if4.b = bv[3:0];
        end
    endtask

    task automatic sample(input int w, output logic bs, output logic dn,
                          output logic e, output logic g, output logic l);
        if (w == 8) begin
            bs = if8.busy; dn = if8.done; e = if8.eq; g = if8.gt; l = if8.lt;
        end else begin
            bs = if4.busy; dn = if4.done; e = if4.eq; g = if4.gt; l = if4.lt;
        end
    endtask

    // Number of edges after the accept edge until done, and busy cycles seen.
    task automatic wait_done(input int w, output int edges, output int bc);
        logic bs, dn, e, g, l;
        edges = 0;
        bc    = 0;
        sample(w, bs, dn, e, g, l);
        while (!dn && edges < 20) begin
            if (bs) bc++;
            tick();
            edges++;
            sample(w, bs, dn, e, g, l);
        end
        if (!dn) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: got no done expected done within 20 edges");
        end
    endtask

    // Reference: result from integer comparison; latency from the first
    // differing 2-bit group counted from the top.
    function automatic int model_lat(input int w, input logic [7:0] av, input logic [7:0] bv);
        int first_diff;
        first_diff = w / 2;
        for (int p = 0; p < w / 2; p++) begin
            if (((av >> (2 * p)) & 8'd3) != ((bv >> (2 * p)) & 8'd3)) first_diff = w / 2 - p;
        end
`ifdef EARLY_EXIT_EN
        return first_diff;
`else
        return (first_diff > 0) ? w / 2 : 0;
`endif
    endfunction

    task automatic do_cmp(input int w, input logic [7:0] av, input logic [7:0] bv, input int lat,
                          input logic e_eq, input logic e_gt, input logic e_lt, input string nm);
        int edges, bc;
        logic bs, dn, e, g, l;
        drive(w, 1'b1, av, bv);
        tick();
        drive(w, 1'b0, av, bv);
        wait_done(w, edges, bc);
        sample(w, bs, dn, e, g, l);
        check({nm, " latency"}, edges, lat);
        check({nm, " busy_cycles"}, bc, lat);
        check({nm, " eq"}, int'(e), int'(e_eq));
        check({nm, " gt"}, int'(g), int'(e_gt));
        check({nm, " lt"}, int'(l), int'(e_lt));
    endtask

    initial begin
        int edges, bc, lat;
        logic [7:0] ra, rb;
        logic bs, dn, e, g, l;

        n_checks = 0;
        n_errors = 0;
        vecs[0] = '{8'hA5, 8'hA5, 1'b1, 1'b0, 1'b0, 4, 4, "vec_a5_a5"};
        vecs[1] = '{8'h80, 8'h7F, 1'b0, 1'b1, 1'b0, 4, 1, "vec_80_7f"};
        vecs[2] = '{8'h12, 8'h13, 1'b0, 1'b0, 1'b1, 4, 4, "vec_12_13"};
        vecs[3] = '{8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 4, 1, "vec_00_ff"};
        vecs[4] = '{8'hFF, 8'hFE, 1'b0, 1'b1, 1'b0, 4, 4, "vec_ff_fe"};
        vecs[5] = '{8'h3C, 8'h0C, 1'b0, 1'b1, 1'b0, 4, 2, "vec_3c_0c"};

        rst_n = 1'b0;
        drive(8, 1'b0, 8'h00, 8'h00);
        drive(4, 1'b0, 8'h00, 8'h00);
        #22;
        sample(8, bs, dn, e, g, l);
        check("reset busy", int'(bs), 0);
        check("reset done", int'(dn), 0);
        check("reset eq", int'(e), 1);
        check("reset gt", int'(g), 0);
        check("reset lt", int'(l), 0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
`ifdef EARLY_EXIT_EN
            lat = vecs[i].lat_early;
`else
            lat = vecs[i].lat_base;
`endif
            do_cmp(8, vecs[i].a, vecs[i].b, lat, vecs[i].eq, vecs[i].gt, vecs[i].lt, vecs[i].nm);
        end

        // Start pulsed while busy must be dropped, not queued.
        drive(8, 1'b1, 8'h12, 8'h13);
        tick();
        drive(8, 1'b0, 8'h12, 8'h13);
        tick();
        tick();
        drive(8, 1'b1, 8'hFF, 8'h00);
        tick();
        drive(8, 1'b0, 8'hFF, 8'h00);
        sample(8, bs, dn, e, g, l);
        check("ignored_start early_done", int'(dn), 0);
        tick();
        sample(8, bs, dn, e, g, l);
        check("ignored_start done", int'(dn), 1);
        check("ignored_start lt", int'(l), 1);
        check("ignored_start gt", int'(g), 0);
        tick();
        sample(8, bs, dn, e, g, l);
        check("ignored_start idle_busy", int'(bs), 0);
        check("ignored_start idle_done", int'(dn), 0);

        // Start held across done chains a second compare.
        drive(8, 1'b1, 8'h12, 8'h13);
        tick();
        drive(8, 1'b1, 8'hA5, 8'hA5);
        wait_done(8, edges, bc);
        sample(8, bs, dn, e, g, l);
        check("held_start first_latency", edges, 4);
        check("held_start first_lt", int'(l), 1);
        tick();
        drive(8, 1'b0, 8'hA5, 8'hA5);
        sample(8, bs, dn, e, g, l);
        check("held_start rerun_busy", int'(bs), 1);
        check("held_start done_pulse", int'(dn), 0);
        check("held_start lt_held", int'(l), 1);
        wait_done(8, edges, bc);
        sample(8, bs, dn, e, g, l);
        check("held_start second_latency", edges, 4);
        check("held_start second_eq", int'(e), 1);

        for (int i = 0; i < 150; i++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
            do_cmp(8, ra, rb, model_lat(8, ra, rb), ra == rb, ra > rb, ra < rb, "rand8");
        end

        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                ra = 8'(x);
                rb = 8'(y);
                do_cmp(4, ra, rb, model_lat(4, ra, rb), ra == rb, ra > rb, ra < rb, "sweep4");
            end
        end

        // Reset in the middle of a compare aborts with no done pulse.
        do_cmp(8, 8'h80, 8'h7F, model_lat(8, 8'h80, 8'h7F), 1'b0, 1'b1, 1'b0, "pre_reset");
        drive(8, 1'b1, 8'h12, 8'h13);
        tick();
        drive(8, 1'b0, 8'h12, 8'h13);
        tick();
        rst_n = 1'b0;
        #1;
        sample(8, bs, dn, e, g, l);
        check("midrun_reset busy", int'(bs), 0);
        check("midrun_reset done", int'(dn), 0);
        check("midrun_reset eq", int'(e), 1);
        check("midrun_reset gt", int'(g), 0);
        check("midrun_reset lt", int'(l), 0);
        tick();
        rst_n = 1'b1;
        bc = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            sample(8, bs, dn, e, g, l);
            if (dn || bs) bc++;
        end
        check("midrun_reset no_activity", bc, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
